// File: rtl/mem_rr_arbiter_if.sv
// Requester and RAM-side signal bundle for mem_rr_arbiter.
// slave = arbiter view, master = requesters/RAM view.
interface mem_rr_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  req0, req1;
    logic                  we0, we1;
    logic [ADDR_WIDTH-1:0] addr0, addr1;
    logic [DATA_WIDTH-1:0] wdata0, wdata1;
    logic                  gnt0, gnt1;
    logic                  rsp_valid0, rsp_valid1;
    logic                  rsp_err0, rsp_err1;
    logic [DATA_WIDTH-1:0] rdata0, rdata1;
    logic                  mem_en, mem_we;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic [DATA_WIDTH-1:0] mem_data_out;
    logic                  mem_valid_out;
    logic                  busy;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  mem_data_out, mem_valid_out,
        output gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_err0, rsp_err1,
        output rdata0, rdata1, mem_en, mem_we, mem_address, mem_data_in, busy
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output mem_data_out, mem_valid_out,
        input  gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_err0, rsp_err1,
        input  rdata0, rdata1, mem_en, mem_we, mem_address, mem_data_in, busy
    );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single-port RAM.
// Optional read timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_rr_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            reset,
    mem_rr_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                state, state_next;
    logic                  rr_ptr, owner, lat_we;
    logic                  mem_en, mem_we, busy;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_data_in, rdata0, rdata1;
    logic                  rsp_valid0, rsp_valid1, rsp_err0, rsp_err1;
    logic                  gnt0_c, gnt1_c, win_c, capture_c, expire_c;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;

    // Counts WAIT cycles; cleared while the access is being issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state == ISSUE) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

    // Next-state, winner selection and combinational grant.
    always_comb begin
        state_next = state;
        gnt0_c     = 1'b0;
        gnt1_c     = 1'b0;
        win_c      = rr_ptr;
        capture_c  = 1'b0;
        expire_c   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    win_c      = (bus.req0 && bus.req1) ? rr_ptr : bus.req1;
                    gnt0_c     = ~win_c;
                    gnt1_c     = win_c;
                    state_next = ISSUE;
                end
            end
            ISSUE: state_next = lat_we ? RESP : WAIT;
            WAIT: begin
                if (bus.mem_valid_out) begin
                    capture_c  = 1'b1;
                    state_next = RESP;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    expire_c   = 1'b1;
                    state_next = RESP;
                end
`endif
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, request latches, RAM drive and per-port response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= 1'b0;
            owner       <= 1'b0;
            lat_we      <= 1'b0;
            busy        <= 1'b0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_address <= '0;
            mem_data_in <= '0;
            rdata0      <= '0;
            rdata1      <= '0;
            rsp_valid0  <= 1'b0;
            rsp_valid1  <= 1'b0;
            rsp_err0    <= 1'b0;
            rsp_err1    <= 1'b0;
        end else begin
            state      <= state_next;
            busy       <= (state_next != IDLE);
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            rsp_valid0 <= (state_next == RESP) && !owner;
            rsp_valid1 <= (state_next == RESP) && owner;
            rsp_err0   <= (state_next == RESP) && !owner && expire_c;
            rsp_err1   <= (state_next == RESP) && owner && expire_c;
            if (gnt0_c || gnt1_c) begin
                owner       <= win_c;
                lat_we      <= win_c ? bus.we1 : bus.we0;
                mem_en      <= 1'b1;
                mem_we      <= win_c ? bus.we1 : bus.we0;
                mem_address <= win_c ? bus.addr1 : bus.addr0;
                mem_data_in <= win_c ? bus.wdata1 : bus.wdata0;
            end
            if (capture_c || expire_c) begin
                if (owner) rdata1 <= capture_c ? bus.mem_data_out : '0;
                else       rdata0 <= capture_c ? bus.mem_data_out : '0;
            end
            if (state == RESP) rr_ptr <= ~owner;
        end
    end

    assign bus.gnt0        = gnt0_c;
    assign bus.gnt1        = gnt1_c;
    assign bus.rsp_valid0  = rsp_valid0;
    assign bus.rsp_valid1  = rsp_valid1;
    assign bus.rsp_err0    = rsp_err0;
    assign bus.rsp_err1    = rsp_err1;
    assign bus.rdata0      = rdata0;
    assign bus.rdata1      = rdata1;
    assign bus.mem_en      = mem_en;
    assign bus.mem_we      = mem_we;
    assign bus.mem_address = mem_address;
    assign bus.mem_data_in = mem_data_in;
    assign bus.busy        = busy;
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Scoreboard bench for mem_rr_arbiter with a 1-cycle-latency RAM model.
module tb_mem_rr_arbiter;
    typedef struct packed {
        logic        port;
        logic        err;
        logic        chk;
        logic [31:0] rdata;
    } exp_t;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic [31:0] ram [16];
    bit   ram_mute;

    mem_rr_arbiter_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();

    mem_rr_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM model: read data and valid one cycle after mem_en.
    always @(posedge clk) begin
        bus.mem_valid_out <= bus.mem_en && !bus.mem_we && !ram_mute;
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_address] <= bus.mem_data_in;
            else            bus.mem_data_out <= ram[bus.mem_address];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every response pulse.
    always @(negedge clk) begin
        exp_t e;
        if (bus.gnt0 || bus.gnt1) check("gnt_exclusive", 32'(bus.gnt0 && bus.gnt1), 32'd0);
        if (bus.rsp_valid0 || bus.rsp_valid1) begin
            check("rsp_exclusive", 32'(bus.rsp_valid0 && bus.rsp_valid1), 32'd0);
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_port", 32'(bus.rsp_valid1), 32'(e.port));
                check("rsp_err", 32'(e.port ? bus.rsp_err1 : bus.rsp_err0), 32'(e.err));
                if (e.chk) check("rsp_rdata", e.port ? bus.rdata1 : bus.rdata0, e.rdata);
            end
        end
    end

    task automatic push(input logic p, input logic err, input logic chk, input logic [31:0] rd);
        exp_t e;
        e.port  = p;
        e.err   = err;
        e.chk   = chk;
        e.rdata = rd;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic p, input logic r, input logic w, input logic [3:0] a,
                         input logic [31:0] d);
        if (p) begin
            bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
        end else begin
            bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
        end
    endtask

    // One access from IDLE: checks grant, issue cycle and response latency.
    task automatic access(input logic p, input logic w, input logic [3:0] a, input logic [31:0] d,
                          input int lat, input logic err, input logic [31:0] rd);
        int n;
        int k;
        drive(p, 1'b1, w, a, d);
        n = 0;
        @(negedge clk);
        while (!(p ? bus.gnt1 : bus.gnt0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("gnt", 32'(p ? bus.gnt1 : bus.gnt0), 32'd1);
        push(p, err, !w, rd);
        @(posedge clk); #1;
        drive(p, 1'b0, w, a, d);
        @(negedge clk);
        check("issue_en", 32'(bus.mem_en), 32'd1);
        check("issue_we", 32'(bus.mem_we), 32'(w));
        check("issue_addr", 32'(bus.mem_address), 32'(a));
        if (w) check("issue_data", bus.mem_data_in, d);
        k = 1;
        forever begin
            @(negedge clk);
            k++;
            if (k == 2) begin
                check("en_drop", 32'(bus.mem_en), 32'd0);
                check("addr_hold", 32'(bus.mem_address), 32'(a));
            end
            if ((p ? bus.rsp_valid1 : bus.rsp_valid0) || k >= 40) break;
        end
        check("rsp_latency", 32'(k), 32'(lat));
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int issued, grants, cyc, last_rsp;
        bit g0, g1, r0, r1;
        reset = 1'b1;
        ram_mute = 1'b0;
        for (int i = 0; i < 16; i++) ram[i] = 32'd0;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_mem_en", 32'(bus.mem_en), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_address), 32'd0);
        check("rst_mem_data", bus.mem_data_in, 32'd0);
        check("rst_rdata0", bus.rdata0, 32'd0);
        check("rst_rdata1", bus.rdata1, 32'd0);
        check("rst_rsp", 32'({bus.rsp_valid0, bus.rsp_valid1, bus.rsp_err0, bus.rsp_err1}), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single write, then read-back on the other port.
        access(1'b0, 1'b1, 4'h3, 32'hDEADBEEF, 2, 1'b0, 32'd0);
        access(1'b1, 1'b0, 4'h3, 32'd0, 3, 1'b0, 32'hDEADBEEF);
        check("rdata0_untouched", bus.rdata0, 32'd0);

        // Contention: both ports re-request after each response.
        drive(1'b0, 1'b1, 1'b1, 4'h8, 32'hA0000001);
        drive(1'b1, 1'b1, 1'b1, 4'h9, 32'hA0000002);
        issued = 2; grants = 0; cyc = 0; last_rsp = -100;
        while (grants < 4 && cyc < 60) begin
            @(negedge clk);
            g0 = bus.gnt0; g1 = bus.gnt1; r0 = bus.rsp_valid0; r1 = bus.rsp_valid1;
            if (g0 || g1) begin
                check("contend_order", 32'(g1), 32'(grants % 2));
                if (grants > 0) check("contend_gap", 32'(cyc), 32'(last_rsp + 1));
                push(g1, 1'b0, 1'b0, 32'd0);
                grants++;
            end
            if (r0 || r1) last_rsp = cyc;
            @(posedge clk); #1;
            cyc++;
            if (g0) bus.req0 = 1'b0;
            if (g1) bus.req1 = 1'b0;
            if (r0 && issued < 4) begin
                issued++;
                drive(1'b0, 1'b1, 1'b1, 4'(7 + issued), 32'hA0000000 | 32'(issued));
            end
            if (r1 && issued < 4) begin
                issued++;
                drive(1'b1, 1'b1, 1'b1, 4'(7 + issued), 32'hA0000000 | 32'(issued));
            end
        end
        check("contend_grants", 32'(grants), 32'd4);
        drain();

        // Busy hold-off: port 1 requests while port 0 waits for read data.
        drive(1'b0, 1'b1, 1'b0, 4'h3, 32'd0);
        @(negedge clk);
        check("hold_gnt0", 32'(bus.gnt0), 32'd1);
        push(1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
        @(posedge clk); #1;
        bus.req0 = 1'b0;
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b0, 4'h9, 32'd0);
        @(negedge clk);
        check("hold_no_gnt1_wait", 32'(bus.gnt1), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("hold_rsp0", 32'(bus.rsp_valid0), 32'd1);
        check("hold_no_gnt1_resp", 32'(bus.gnt1), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("hold_gnt1", 32'(bus.gnt1), 32'd1);
        push(1'b1, 1'b0, 1'b1, 32'hA0000002);
        @(posedge clk); #1;
        bus.req1 = 1'b0;
        drain();

        // Reset mid-read; pointer left at 1 by a port-0 write beforehand.
        access(1'b0, 1'b1, 4'hC, 32'h12345678, 2, 1'b0, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 4'hC, 32'd0);
        @(negedge clk);
        check("abort_gnt1", 32'(bus.gnt1), 32'd1);
        @(posedge clk); #1;
        bus.req1 = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy_wait", 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_mem_en", 32'(bus.mem_en), 32'd0);
        check("abort_no_rsp", 32'({bus.rsp_valid0, bus.rsp_valid1}), 32'd0);
        check("abort_rdata0", bus.rdata0, 32'd0);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 4'hC, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 4'h3, 32'd0);
        @(negedge clk);
        check("abort_ptr_gnt0", 32'(bus.gnt0), 32'd1);
        check("abort_ptr_gnt1", 32'(bus.gnt1), 32'd0);
        push(1'b0, 1'b0, 1'b1, 32'h12345678);
        @(posedge clk); #1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        drain();

        // RAM never returns valid.
        ram_mute = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
        access(1'b0, 1'b0, 4'h3, 32'd0, 18, 1'b1, 32'd0);
        ram_mute = 1'b0;
`else
        drive(1'b0, 1'b1, 1'b0, 4'h3, 32'd0);
        @(negedge clk);
        check("stall_gnt0", 32'(bus.gnt0), 32'd1);
        @(posedge clk); #1;
        bus.req0 = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("stall_busy", 32'(bus.busy), 32'd1);
        check("stall_no_rsp", 32'(bus.rsp_valid0), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        ram_mute = 1'b0;
        @(negedge clk);
        check("stall_reset_busy", 32'(bus.busy), 32'd0);
`endif
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
